bb_dot_sched: RTL and testbench
===============================

// Module: bb_dot_sched
// PURPOSE
//  Issue scheduler and shift-accumulator for the 8x8 unsigned bit-blade PE.
//  - Accepts one 16-lane vector pair of 8-bit unsigned operands.
//  - Slices each operand into 2-bit digits and issues the 16 (i,j) digit-pair
//    combinations to the PE, one per cycle. Each PE word is lane-packed 2 bits per lane.
//  - Shifts each registered PE partial sum by 2*(i+j) and accumulates it,
//    producing a 16-element dot product.
//  - Dot products accumulate across vectors until one is tagged last.
// PARAMETERS
//  ACC_W   32  accumulator/result width (min 20 for one full vector)
//  PE_LAT  1   PE output latency in cycles (>=1)
// PORTS
//  clk        in   1        clock; all logic on rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        operand vector pair valid
//  in_ready   out  1        scheduler can accept operands
//  in_last    in   1        this vector closes the current dot product
//  vec_a      in   128      lane k = vec_a[8k+7:8k], k=0..15, unsigned
//  vec_b      in   128      lane k = vec_b[8k+7:8k], k=0..15, unsigned
//  pe_in1     out  32       to PE in1; bits [2k+1:2k] = digit i of a_k
//  pe_in2     out  32       to PE in2; bits [2k+1:2k] = digit j of b_k
//  pe_out     in   8        registered PE sum, valid PE_LAT cycles after issue
//  out_valid  out  1        dot-product result valid
//  out_ready  in   1        consumer accepts result
//  out_acc    out  ACC_W    accumulated result, modulo 2^ACC_W
//  out_ovf    out  1        sticky: some accumulate wrapped in this result
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset:
//  - state=IDLE; acc, out_acc, out_ovf, out_valid, pe_in1 and pe_in2 are 0.
//  - Issue/valid delay pipe is cleared. in_ready=1 in the first cycle after rst.
//  - Reset mid-run discards latched operands and the partial accumulation.
//  States: IDLE -> RUN -> DRAIN -> (DONE | IDLE); DONE -> IDLE.
//  IDLE:
//  - in_ready=1.
//  - in_valid&in_ready at edge T latches vec_a, vec_b and in_last, then enters RUN.
//  RUN: 16 cycles, step s=0..15.
//  - Digit indices: i=s[1:0], j=s[3:2]; shift is 2*(i+j), range 0..12.
//  - Step s drives pe_in1/pe_in2 during cycle T+1+s.
//  - Outside RUN, pe_in1 and pe_in2 are driven to 0.
//  DRAIN: PE_LAT cycles, waiting for the last partial sum to arrive.
//  Accumulate:
//  - A PE_LAT-deep pipe carries a valid bit and the shift amount alongside each issue.
//  - When the pipe output is valid: acc <= acc + (pe_out << shift), computed mod 2^ACC_W.
//  - A carry-out sets the sticky ovf bit.
//  - pe_out is ignored whenever the pipe output is not valid, so stale PE contents are harmless.
//  End of DRAIN:
//  - If last: out_acc <= final acc, out_ovf <= ovf, out_valid=1, go to DONE.
//  - Otherwise go to IDLE with acc retained (no result is emitted).
//  DONE:
//  - out_valid is held with out_acc and out_ovf stable until out_ready=1.
//  - On the handshake edge: acc and ovf clear, out_valid=0, next state IDLE.
//  Timing and ordering:
//  - With PE_LAT=1, an accept at edge T gives out_valid=1 at T+18.
//  - Throughput is one vector per 17+PE_LAT cycles plus the DONE handshake.
//  - in_ready=0 in RUN, DRAIN and DONE; operands are never accepted while a result is pending.
//  - A dot-product group may contain any number of vectors; only the last-tagged vector emits.
//  - Per-step bound: pe_out <= 144, so shifted term < 2^20; one-vector max is 16*255*255 = 1040400.
// TESTING
//  1. All lanes a=b=255, last=1 -> out_acc=1040400, out_ovf=0, out_valid at accept+18.
//  2. a_k=k+1, b_k=1, last=1 -> out_acc=136. Then a_k=3, b_k=200, last=1 -> out_acc=9600, proving acc was cleared.
//  3. Group of two vectors: a=b=2 (last=0) then a=b=3 (last=1) -> single result 64+144=208; no out_valid after the first vector.
//  4. Hold out_ready=0 for 10 cycles in DONE:
//     - out_valid and out_acc stay stable; in_ready stays 0.
//     - Raise out_ready: in_ready=1 on the next cycle.
//  5. Assert rst at RUN step 7:
//     - Next cycle: IDLE, in_ready=1, pe_in1/pe_in2=0.
//     - Next vector a=b=1, last=1 -> out_acc=16.
//  6. ACC_W=20, two vectors of all-255 in one group -> out_acc=1032224 (2080800 mod 2^20), out_ovf=1.

Source files
------------

// File: rtl/bb_dot_sched.sv
// Issue scheduler and shift-accumulator for the 8x8 unsigned bit-blade PE.
// Each latched 16-lane operand pair is sliced into 2-bit digits. The 16 digit-pair
// combinations are issued to the PE, one per cycle. Every returned partial sum is
// shifted by 2*(i+j) and accumulated. A result is emitted only for a vector tagged last.
module bb_dot_sched #(
  parameter int ACC_W  = 32,
  parameter int PE_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [127:0]     vec_a,
  input  logic [127:0]     vec_b,
  output logic [31:0]      pe_in1,
  output logic [31:0]      pe_in2,
  input  logic [7:0]       pe_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [127:0]     a_q, b_q;
  logic             last_q;
  logic [3:0]       step;
  logic [DW-1:0]    drain_cnt;
  logic             drain_done;
  logic [2:0]       dsum;
  logic [3:0]       issue_sh;
  logic             issue;
  logic [PE_LAT-1:0] pv;
  logic [3:0]       psh [PE_LAT];
  logic [ACC_W-1:0] acc, acc_nxt, term;
  logic [ACC_W:0]   sum_ext;
  logic             ovf, ovf_nxt;

  assign drain_done = (drain_cnt == DW'(PE_LAT - 1));
  assign issue      = (state == RUN);
  assign dsum       = {1'b0, step[1:0]} + {1'b0, step[3:2]};
  assign issue_sh   = {dsum, 1'b0};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN:   if (step == 4'd15) state_nxt = DRAIN;
      DRAIN: if (drain_done) state_nxt = last_q ? DONE : IDLE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit issue: lane k takes digit i of a_k and digit j of b_k; zero outside RUN.
  always_comb begin
    pe_in1 = '0;
    pe_in2 = '0;
    if (state == RUN) begin
      for (int unsigned k = 0; k < 16; k++) begin
        pe_in1[2*k +: 2] = a_q[8*k + 2*int'(step[1:0]) +: 2];
        pe_in2[2*k +: 2] = b_q[8*k + 2*int'(step[3:2]) +: 2];
      end
    end
  end

  // Valid/shift pipe aligned to the PE latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int unsigned i = 0; i < PE_LAT; i++) psh[i] <= '0;
    end else begin
      pv[0]  <= issue;
      psh[0] <= issue_sh;
      for (int unsigned i = 1; i < PE_LAT; i++) begin
        pv[i]  <= pv[i-1];
        psh[i] <= psh[i-1];
      end
    end
  end

  // Shifted partial-sum accumulate with carry-out detection.
  always_comb begin
    term    = {{(ACC_W-8){1'b0}}, pe_out} << psh[PE_LAT-1];
    sum_ext = {1'b0, acc} + {1'b0, term};
    acc_nxt = acc;
    ovf_nxt = ovf;
    if (pv[PE_LAT-1]) begin
      acc_nxt = sum_ext[ACC_W-1:0];
      ovf_nxt = ovf | sum_ext[ACC_W];
    end
  end

  // Operand latch, step/drain counters, accumulator and result registers.
  // The result captures acc_nxt so the final partial sum arriving on the last
  // DRAIN cycle is included without an extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      last_q    <= 1'b0;
      step      <= '0;
      drain_cnt <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      acc <= acc_nxt;
      ovf <= ovf_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= vec_a;
            b_q    <= vec_b;
            last_q <= in_last;
          end
          step      <= '0;
          drain_cnt <= '0;
        end
        RUN:   step <= step + 4'd1;
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_done && last_q) begin
            out_acc <= acc_nxt;
            out_ovf <= ovf_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc <= '0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bb_dot_sched.sv
// Bench for bb_dot_sched: two instances (ACC_W=32/PE_LAT=1 and ACC_W=20/PE_LAT=2)
// share stimulus; a behavioural PE feeds each, and expected results come from
// plain dot-product arithmetic on the operand vectors.
module tb_bb_dot_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_last, out_ready;
  logic [127:0] vec_a, vec_b;

  logic         in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [31:0]  pe_in1_a, pe_in2_a, out_acc_a;
  logic [7:0]   pe_out_a;

  logic         in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [31:0]  pe_in1_b, pe_in2_b;
  logic [19:0]  out_acc_b;
  logic [7:0]   pe_out_b, pe_b_s1;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint grp_sum = 0;

  always #5 clk = ~clk;

  bb_dot_sched #(.ACC_W(32), .PE_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
    .vec_a(vec_a), .vec_b(vec_b), .pe_in1(pe_in1_a), .pe_in2(pe_in2_a), .pe_out(pe_out_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a), .out_ovf(out_ovf_a),
    .busy(busy_a)
  );

  bb_dot_sched #(.ACC_W(20), .PE_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
    .vec_a(vec_a), .vec_b(vec_b), .pe_in1(pe_in1_b), .pe_in2(pe_in2_b), .pe_out(pe_out_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b), .out_ovf(out_ovf_b),
    .busy(busy_b)
  );

  function automatic logic [7:0] pe_f(input logic [31:0] x, input logic [31:0] y);
    int s;
    s = 0;
    for (int k = 0; k < 16; k++) s += int'(x[2*k +: 2]) * int'(y[2*k +: 2]);
    return 8'(s);
  endfunction

  // Behavioural PE; while the scheduler idles it produces junk that must be ignored.
  always @(posedge clk) begin
    pe_out_a <= busy_a ? pe_f(pe_in1_a, pe_in2_a) : 8'($urandom);
    pe_b_s1  <= busy_b ? pe_f(pe_in1_b, pe_in2_b) : 8'($urandom);
    pe_out_b <= pe_b_s1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint dot(input logic [127:0] a, input logic [127:0] b);
    longint s;
    s = 0;
    for (int k = 0; k < 16; k++) s += longint'(a[8*k +: 8]) * longint'(b[8*k +: 8]);
    return s;
  endfunction

  function automatic logic [31:0] digits(input logic [127:0] v, input int d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[2*k +: 2] = v[8*k + 2*d +: 2];
    return r;
  endfunction

  function automatic logic [127:0] splat(input logic [7:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = x;
    return r;
  endfunction

  function automatic logic [127:0] rnd_vec();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(in_ready_a && in_ready_b) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_val("accept_timeout", 1, 0);
  endtask

  // Issue one vector; called and returns at a negedge. Cycle c=1 is the cycle after accept.
  task automatic send_vec(input logic [127:0] a, input logic [127:0] b, input logic last);
    int   ov_a, ov_b, rdy_a, rdy_b;
    logic early;
    longint m20;
    ov_a = 0; ov_b = 0; rdy_a = 0; rdy_b = 0; early = 1'b0;
    wait_ready();
    vec_a = a; vec_b = b; in_last = last; in_valid = 1'b1;
    grp_sum += dot(a, b);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid_a && ov_a == 0) ov_a = c;
      if (out_valid_b && ov_b == 0) ov_b = c;
      if (in_ready_a && rdy_a == 0) rdy_a = c;
      if (in_ready_b && rdy_b == 0) rdy_b = c;
      if ((in_ready_a && c < 18) || (in_ready_b && c < 19)) early = 1'b1;
      if (last ? (ov_a != 0 && ov_b != 0) : (rdy_a != 0 && rdy_b != 0)) break;
    end
    check_val("busy_ready_low", 64'(early), 0);
    if (last) begin
      m20 = grp_sum & 64'hFFFFF;
      check_val("lat_a", 64'(ov_a), 18);
      check_val("lat_b", 64'(ov_b), 19);
      check_val("acc_a", 64'(out_acc_a), 64'(grp_sum & 64'hFFFF_FFFF));
      check_val("ovf_a", 64'(out_ovf_a), 64'(grp_sum >= 64'h1_0000_0000));
      check_val("acc_b", 64'(out_acc_b), 64'(m20));
      check_val("ovf_b", 64'(out_ovf_b), 64'(grp_sum >= 64'h10_0000));
      grp_sum = 0;
    end else begin
      check_val("idle_lat_a", 64'(rdy_a), 18);
      check_val("idle_lat_b", 64'(rdy_b), 19);
      check_val("no_result", 64'(ov_a + ov_b), 0);
    end
  endtask

  // Hold the result for 'hold' cycles, then complete the handshake.
  task automatic collect(input int hold);
    logic [31:0] snap_a;
    logic [19:0] snap_b;
    logic        bad;
    snap_a = out_acc_a; snap_b = out_acc_b; bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!out_valid_a || !out_valid_b || in_ready_a || in_ready_b ||
          out_acc_a !== snap_a || out_acc_b !== snap_b) bad = 1'b1;
    end
    check_val("hold_stable", 64'(bad), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("post_hs_ready", {62'd0, in_ready_a, in_ready_b}, 3);
    check_val("post_hs_valid", {62'd0, out_valid_a, out_valid_b}, 0);
  endtask

  // Reset asserted while RUN step 7 is on the PE inputs.
  task automatic reset_mid_run(input logic [127:0] a, input logic [127:0] b);
    wait_ready();
    vec_a = a; vec_b = b; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("step0_in1", 64'(pe_in1_a), 64'(digits(a, 0)));
    check_val("step0_in2", 64'(pe_in2_b), 64'(digits(b, 0)));
    repeat (7) @(negedge clk);
    check_val("step7_in1", 64'(pe_in1_b), 64'(digits(a, 3)));
    check_val("step7_in2", 64'(pe_in2_a), 64'(digits(b, 1)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_ready", {62'd0, in_ready_a, in_ready_b}, 3);
    check_val("rst_pe_in", {pe_in1_a, pe_in2_a} | {pe_in1_b, pe_in2_b}, 0);
    check_val("rst_busy", {62'd0, busy_a, busy_b}, 0);
    grp_sum = 0;
  endtask

  initial begin
    logic [127:0] a, b;
    int nv;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    vec_a = '0; vec_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_ready", {62'd0, in_ready_a, in_ready_b}, 3);
    check_val("reset_valid", {62'd0, out_valid_a, out_valid_b}, 0);
    check_val("reset_acc", {out_acc_a, 12'd0, out_acc_b}, 0);
    check_val("reset_ovf", {62'd0, out_ovf_a, out_ovf_b}, 0);
    check_val("reset_pe_in", {pe_in1_a, pe_in2_a} | {pe_in1_b, pe_in2_b}, 0);

    // All-255 single vector: 1040400.
    send_vec(splat(8'd255), splat(8'd255), 1'b1);
    check_val("max_vec", 64'(out_acc_a), 1040400);
    collect(0);

    // Ramp then a fresh vector to show the accumulator cleared.
    for (int k = 0; k < 16; k++) a[8*k +: 8] = 8'(k + 1);
    send_vec(a, splat(8'd1), 1'b1);
    check_val("ramp", 64'(out_acc_a), 136);
    collect(1);
    send_vec(splat(8'd3), splat(8'd200), 1'b1);
    check_val("after_clear", 64'(out_acc_a), 9600);
    collect(0);

    // Two-vector group, then a long consumer stall.
    send_vec(splat(8'd2), splat(8'd2), 1'b0);
    send_vec(splat(8'd3), splat(8'd3), 1'b1);
    check_val("group2", 64'(out_acc_a), 208);
    collect(10);

    // Reset mid-run, then a clean small vector.
    reset_mid_run(rnd_vec(), rnd_vec());
    send_vec(splat(8'd1), splat(8'd1), 1'b1);
    check_val("post_rst", 64'(out_acc_a), 16);
    collect(0);

    // Overflow in the 20-bit instance.
    send_vec(splat(8'd255), splat(8'd255), 1'b0);
    send_vec(splat(8'd255), splat(8'd255), 1'b1);
    check_val("wrap20", 64'(out_acc_b), 1032224);
    check_val("wrap20_ovf", 64'(out_ovf_b), 1);
    collect(2);

    // Random groups of 1..3 vectors.
    for (int g = 0; g < 10; g++) begin
      nv = int'($urandom_range(1, 3));
      for (int v = 0; v < nv; v++) begin
        a = rnd_vec();
        b = rnd_vec();
        send_vec(a, b, v == nv - 1);
      end
      collect(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
